nonce_collector: RTL and testbench

- Parameterised result-gathering stage for cluster hubs.
- Sits between the per-slave serial receivers (32-bit nonce plus a one-cycle new_nonce strobe each) and the uplink serial transmitter (send/busy handshake).
- Captures every reported nonce, arbitrates round-robin across SLAVES, buffers results in a FIFO and feeds them to the uplink one word at a time.
- Replaces the fixed two-slave flag logic in hubs and supports any number of slaves.

---
 rtl/nonce_collector.sv | 184 ++++++++++++++++++
 tb/tb_nonce_collector.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_collector.sv
// Gathers per-slave nonces, round-robin arbitrates them into a FIFO, feeds uplink.
// Optional NONCE_COLLECTOR_DEDUP_EN drops a push equal to the last pushed word.
module nonce_collector #(
  parameter int SLAVES      = 2,
  parameter int FIFO_LOG2   = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   hash_clk,
  input  logic                   reset_n,
  input  logic [SLAVES*32-1:0]   slave_nonces,
  input  logic [SLAVES-1:0]      new_nonces,
  input  logic                   serial_busy,
  output logic                   serial_send,
  output logic [31:0]            golden_nonce,
  output logic [FIFO_LOG2:0]     fifo_count,
  output logic [7:0]             dropped
);

  localparam int PW    = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  logic [31:0]          hold [SLAVES];
  logic [SLAVES-1:0]    pend;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        gnt;
  logic [PW:0]          cand;
  logic                 gnt_vld;
  logic [31:0]          gnt_word;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [31:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0] wptr;
  logic [FIFO_LOG2-1:0] rptr;
  logic [31:0]          head;
  state_t               state;
  logic [TW-1:0]        tmo;
  int                   nd;
  int                   dsum;

  assign full  = (fifo_count == (FIFO_LOG2+1)'(DEPTH));
  assign empty = (fifo_count == '0);
  assign head  = mem[rptr];

  // First pending slave at or after rr_ptr, wrapping modulo SLAVES.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int k = 0; k < SLAVES; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(SLAVES))
        cand = cand - (PW+1)'(SLAVES);
      if (!gnt_vld && pend[cand[PW-1:0]] && !full) begin
        gnt_vld = 1'b1;
        gnt     = cand[PW-1:0];
      end
    end
  end

  assign gnt_word = hold[gnt];

`ifdef NONCE_COLLECTOR_DEDUP_EN
  logic [31:0] last_word;
  logic        last_valid;

  assign push = gnt_vld &&
                !(last_valid && (gnt_word == last_word));

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_word  <= '0;
      last_valid <= 1'b0;
    end else if (push) begin
      last_word  <= gnt_word;
      last_valid <= 1'b1;
    end
  end
`else
  assign push = gnt_vld;
`endif

  assign pop = (state == IDLE) && !empty && !serial_busy;

  // A strobe on a still-pending slave loses the old word, unless that
  // slave is being granted this very cycle.
  always_comb begin
    nd = 0;
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i] && pend[i] &&
          !(gnt_vld && (gnt == PW'(i))))
        nd++;
    end
    dsum = int'(dropped) + nd;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= '0;
      rr_ptr  <= '0;
      dropped <= '0;
      for (int i = 0; i < SLAVES; i++)
        hold[i] <= '0;
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) begin
          hold[i] <= slave_nonces[i*32 +: 32];
          pend[i] <= 1'b1;
        end else if (gnt_vld && (gnt == PW'(i))) begin
          pend[i] <= 1'b0;
        end
      end
      if (gnt_vld)
        rr_ptr <= (gnt == PW'(SLAVES-1)) ? '0 : gnt + 1'b1;
      dropped <= (dsum > 255) ? 8'hff : 8'(dsum);
    end
  end

  always_ff @(posedge hash_clk) begin
    if (push)
      mem[wptr] <= gnt_word;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      serial_send  <= 1'b0;
      golden_nonce <= '0;
      tmo          <= '0;
    end else begin
      serial_send <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            golden_nonce <= head;
            serial_send  <= 1'b1;
            tmo          <= '0;
            state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (serial_busy)
            state <= WAIT_DONE;
          else if (tmo == TW'(ACK_TIMEOUT-1))
            state <= IDLE;
          else
            tmo <= tmo + 1'b1;
        end
        WAIT_DONE: begin
          if (!serial_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_collector.sv
// Randomised self-checking bench for nonce_collector (SLAVES=4).
// Expected words come from a round-robin/queue model of the collector.
module tb_nonce_collector;

  localparam int S     = 4;
  localparam int FL    = 3;
  localparam int AT    = 15;
  localparam int DEPTH = 8;

  logic              hash_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [S*32-1:0]   slave_nonces = '0;
  logic [S-1:0]      new_nonces = '0;
  logic              serial_busy = 1'b0;
  logic              serial_send;
  logic [31:0]       golden_nonce;
  logic [FL:0]       fifo_count;
  logic [7:0]        dropped;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int busy_mode = 0;
  int rr_ptr_m = 0;
  logic [31:0] got [$];
  int          got_cyc [$];
  logic [31:0] exp_q [$];

  nonce_collector #(
    .SLAVES(S),
    .FIFO_LOG2(FL),
    .ACK_TIMEOUT(AT)
  ) dut (
    .hash_clk(hash_clk),
    .reset_n(reset_n),
    .slave_nonces(slave_nonces),
    .new_nonces(new_nonces),
    .serial_busy(serial_busy),
    .serial_send(serial_send),
    .golden_nonce(golden_nonce),
    .fifo_count(fifo_count),
    .dropped(dropped)
  );

  always #5 hash_clk = ~hash_clk;

  always @(posedge hash_clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge hash_clk);
    if (serial_send) begin
      got.push_back(golden_nonce);
      got_cyc.push_back(cyc);
    end
  end

  // Uplink model: 0 idle, 1 stuck busy, 2 busy for 5 cycles after each send.
  initial forever begin
    @(negedge hash_clk);
    if (busy_mode == 1) begin
      serial_busy = 1'b1;
    end else if (busy_mode == 2 && serial_send) begin
      repeat (2) @(negedge hash_clk);
      serial_busy = 1'b1;
      repeat (5) @(negedge hash_clk);
      serial_busy = 1'b0;
    end else begin
      serial_busy = 1'b0;
    end
  end

  function automatic void rr_expect(input logic [S-1:0] m,
                                    input logic [S*32-1:0] v);
    int last;
    last = 0;
    for (int k = 0; k < S; k++) begin
      int s;
      s = (rr_ptr_m + k) % S;
      if (m[s]) begin
        exp_q.push_back(v[s*32 +: 32]);
        last = s;
      end
    end
    if (m != '0)
      rr_ptr_m = (last + 1) % S;
  endfunction

  task automatic strobe(input logic [S-1:0] m,
                        input logic [S*32-1:0] v);
    @(negedge hash_clk);
    slave_nonces = v;
    new_nonces   = m;
    @(negedge hash_clk);
    new_nonces   = '0;
  endtask

  task automatic strobe1(input int s, input logic [31:0] w);
    logic [S*32-1:0] v;
    v = '0;
    v[s*32 +: 32] = w;
    strobe(S'(1) << s, v);
  endtask

  task automatic wait_sends(input int n, input int budget,
                            output bit ok);
    int b;
    b = budget;
    while (got.size() < n && b > 0) begin
      @(negedge hash_clk);
      b--;
    end
    ok = (got.size() >= n);
  endtask

  task automatic do_reset();
    busy_mode = 0;
    repeat (10) @(negedge hash_clk);
    reset_n = 1'b0;
    new_nonces = '0;
    repeat (2) @(negedge hash_clk);
    reset_n = 1'b1;
    rr_ptr_m = 0;
    exp_q.delete();
    @(negedge hash_clk);
  endtask

  task automatic check_stream(input string nm, input int base);
    vec++;
    if (got.size() - base != exp_q.size()) begin
      errs++;
      $display("FAIL %s_count: got %0d want %0d", nm,
               got.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vec++;
      if (base + i >= got.size()) begin
        errs++;
        $display("FAIL %s[%0d]: got none want %h", nm, i, exp_q[i]);
      end else if (got[base+i] !== exp_q[i]) begin
        errs++;
        $display("FAIL %s[%0d]: got %h want %h", nm, i,
                 got[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge hash_clk);
    vec++;
    if (serial_send !== 1'b0) begin
      errs++; $display("FAIL rst_send: got %b want 0", serial_send);
    end
    vec++;
    if (golden_nonce !== 32'h0) begin
      errs++; $display("FAIL rst_golden: got %h want 0", golden_nonce);
    end
    vec++;
    if (fifo_count !== '0) begin
      errs++; $display("FAIL rst_count: got %0d want 0", fifo_count);
    end
    vec++;
    if (dropped !== 8'h0) begin
      errs++; $display("FAIL rst_dropped: got %0d want 0", dropped);
    end
    reset_n = 1'b1;
    @(negedge hash_clk);
  endtask

  task automatic test_latency();
    busy_mode = 0;
    for (int t = 0; t < 4; t++) begin
      logic [31:0] w;
      w = (t == 0) ? 32'hDEADBEEF : $urandom;
      strobe1(0, w);
      vec++;
      if (serial_send !== 1'b0) begin
        errs++; $display("FAIL lat_c1: got %b want 0", serial_send);
      end
      @(negedge hash_clk);
      vec++;
      if (serial_send !== 1'b0) begin
        errs++; $display("FAIL lat_c2: got %b want 0", serial_send);
      end
      @(negedge hash_clk);
      vec++;
      if (serial_send !== 1'b1) begin
        errs++; $display("FAIL lat_c3: got %b want 1", serial_send);
      end
      vec++;
      if (golden_nonce !== w) begin
        errs++; $display("FAIL lat_word: got %h want %h", golden_nonce, w);
      end
      vec++;
      if (dropped !== 8'h0) begin
        errs++; $display("FAIL lat_drop: got %0d want 0", dropped);
      end
      repeat (25) @(negedge hash_clk);
    end
  endtask

  task automatic test_round_robin();
    logic [S*32-1:0] v;
    int base;
    bit ok;
    do_reset();
    busy_mode = 2;
    base = got.size();
    for (int k = 0; k < S; k++)
      v[k*32 +: 32] = 32'h11111111 * (k + 1);
    strobe('1, v);
    rr_expect('1, v);
    v = '0;
    v[32 +: 32] = $urandom;
    strobe(4'b0010, v);
    rr_expect(4'b0010, v);
    wait_sends(base + exp_q.size(), 200, ok);
    for (int k = 0; k < S; k++)
      v[k*32 +: 32] = $urandom;
    strobe('1, v);
    rr_expect('1, v);
    wait_sends(base + exp_q.size(), 200, ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL rr_timeout: got %0d want %0d",
                       got.size() - base, exp_q.size());
    end
    check_stream("rr", base);
  endtask

  task automatic test_fifo_full();
    int base;
    bit ok;
    logic [31:0] w;
    do_reset();
    busy_mode = 1;
    base = got.size();
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = $urandom;
      strobe1(1, w);
      exp_q.push_back(w);
      @(negedge hash_clk);
    end
    repeat (3) @(negedge hash_clk);
    vec++;
    if (fifo_count !== 4'(DEPTH)) begin
      errs++; $display("FAIL full_count: got %0d want %0d",
                       fifo_count, DEPTH);
    end
    vec++;
    if (got.size() != base) begin
      errs++; $display("FAIL full_sent: got %0d want 0", got.size() - base);
    end
    busy_mode = 2;
    repeat (30) @(negedge hash_clk);
    w = $urandom;
    strobe1(1, w);
    exp_q.push_back(w);
    wait_sends(base + 10, 400, ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL full_timeout: got %0d want 10",
                       got.size() - base);
    end
    check_stream("full", base);
    vec++;
    if (dropped !== 8'h0) begin
      errs++; $display("FAIL full_drop: got %0d want 0", dropped);
    end
  endtask

  task automatic test_drop();
    int base;
    bit ok;
    logic [31:0] w, a, b;
    do_reset();
    busy_mode = 1;
    base = got.size();
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      strobe1(0, w);
      exp_q.push_back(w);
    end
    a = $urandom;
    b = a ^ 32'h5A5A0001;
    strobe1(0, a);
    @(negedge hash_clk);
    strobe1(0, b);
    exp_q.push_back(b);
    @(negedge hash_clk);
    vec++;
    if (dropped !== 8'd1) begin
      errs++; $display("FAIL drop_cnt: got %0d want 1", dropped);
    end
    busy_mode = 2;
    wait_sends(base + DEPTH + 1, 400, ok);
    repeat (20) @(negedge hash_clk);
    check_stream("drop", base);
    for (int i = base; i < got.size(); i++) begin
      vec++;
      if (got[i] === a) begin
        errs++; $display("FAIL drop_lost: got %h want absent", a);
      end
    end
    vec++;
    if (dropped !== 8'd1) begin
      errs++; $display("FAIL drop_hold: got %0d want 1", dropped);
    end
  endtask

  task automatic test_timeout();
    int base;
    bit ok;
    logic [31:0] w0, w1;
    do_reset();
    busy_mode = 0;
    base = got.size();
    w0 = $urandom;
    w1 = ~w0;
    strobe1(3, w0);
    strobe1(3, w1);
    wait_sends(base + 2, 100, ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL tmo_timeout: got %0d want 2", got.size() - base);
    end else begin
      vec++;
      if (got_cyc[base+1] - got_cyc[base] != AT + 1) begin
        errs++; $display("FAIL tmo_gap: got %0d want %0d",
                         got_cyc[base+1] - got_cyc[base], AT + 1);
      end
      vec++;
      if (got[base] !== w0 || got[base+1] !== w1) begin
        errs++; $display("FAIL tmo_words: got %h %h want %h %h",
                         got[base], got[base+1], w0, w1);
      end
    end
    repeat (20) @(negedge hash_clk);
  endtask

  task automatic test_dedup();
    int base;
    int want;
    logic [S*32-1:0] v;
    do_reset();
    busy_mode = 2;
    base = got.size();
    v = '0;
    v[0 +: 32]  = 32'hCAFEF00D;
    v[32 +: 32] = 32'hCAFEF00D;
    strobe(4'b0011, v);
    repeat (60) @(negedge hash_clk);
`ifdef NONCE_COLLECTOR_DEDUP_EN
    want = 1;
`else
    want = 2;
`endif
    vec++;
    if (got.size() - base != want) begin
      errs++; $display("FAIL dedup_sends: got %0d want %0d",
                       got.size() - base, want);
    end
    vec++;
    if (got.size() > base && got[base] !== 32'hCAFEF00D) begin
      errs++; $display("FAIL dedup_word: got %h want cafef00d", got[base]);
    end
    vec++;
    if (dropped !== 8'h0) begin
      errs++; $display("FAIL dedup_drop: got %0d want 0", dropped);
    end
  endtask

  task automatic test_random();
    int base;
    bit ok;
    logic [S-1:0] m;
    logic [S*32-1:0] v;
    do_reset();
    busy_mode = 2;
    base = got.size();
    for (int it = 0; it < 12; it++) begin
      m = S'($urandom_range(1, (1 << S) - 1));
      for (int k = 0; k < S; k++)
        v[k*32 +: 32] = $urandom;
      strobe(m, v);
      rr_expect(m, v);
      repeat ($urandom_range(45, 55)) @(negedge hash_clk);
    end
    wait_sends(base + exp_q.size(), 500, ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL rnd_timeout: got %0d want %0d",
                       got.size() - base, exp_q.size());
    end
    check_stream("rnd", base);
    vec++;
    if (dropped !== 8'h0) begin
      errs++; $display("FAIL rnd_drop: got %0d want 0", dropped);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_fifo_full();
    test_drop();
    test_timeout();
    test_dedup();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
